// File: rtl/ssc_regbank_pkg.sv
// Shared constants and types for the register bank and its write-port arbiter.
package ssc_regbank_pkg;
    localparam int unsigned N_REQ  = 3;
    localparam int unsigned N_REGS = 16;
    localparam int unsigned DATA_W = 20;
    localparam int unsigned ADDR_W = 4;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Pointer width for a round-robin over n requesters, never below one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-back request bus between the pipeline requesters and the register bank arbiter.
interface regfile_write_arbiter_if
    import ssc_regbank_pkg::*;
#(
    parameter int unsigned N_REQ  = ssc_regbank_pkg::N_REQ,
    parameter int unsigned N_REGS = ssc_regbank_pkg::N_REGS,
    parameter int unsigned DATA_W = ssc_regbank_pkg::DATA_W,
    parameter int unsigned ADDR_W = ssc_regbank_pkg::ADDR_W
);
    logic                       stall;
    logic [N_REQ-1:0]           req;
    logic [N_REQ*ADDR_W-1:0]    req_addr;
    logic [N_REQ*DATA_W-1:0]    req_data;
    logic [N_REQ-1:0]           gnt;
    logic [N_REGS-1:0]          wr_en;
    logic [DATA_W-1:0]          wr_data;
    logic                       addr_err;
    logic                       busy;

    modport master (
        output stall, req, req_addr, req_data,
        input  gnt, wr_en, wr_data, addr_err, busy
    );

    modport slave (
        input  stall, req, req_addr, req_data,
        output gnt, wr_en, wr_data, addr_err, busy
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index scanning from ptr, wrapping.
module rr_picker
    import ssc_regbank_pkg::*;
#(
    parameter int unsigned N = ssc_regbank_pkg::N_REQ,
    localparam int unsigned PTR_W = ptr_w(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win_c,
    output logic             valid_c
);
    logic [PTR_W-1:0] idx;

    always_comb begin
        win_c   = '0;
        valid_c = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PTR_W'((32'(ptr) + i) % N);
            if (!valid_c && elig[idx]) begin
                win_c[idx] = 1'b1;
                valid_c    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port among N_REQ requesters.
// Optional macro ZERO_REG_PROTECT_EN makes address 0 a hardwired-zero register.
module regfile_write_arbiter
    import ssc_regbank_pkg::*;
#(
    parameter int unsigned N_REQ  = ssc_regbank_pkg::N_REQ,
    parameter int unsigned N_REGS = ssc_regbank_pkg::N_REGS,
    parameter int unsigned DATA_W = ssc_regbank_pkg::DATA_W,
    parameter int unsigned ADDR_W = ssc_regbank_pkg::ADDR_W
) (
    input logic                     clk,
    input logic                     rst,
    regfile_write_arbiter_if.slave  bus
);
    localparam int unsigned PTR_W = ptr_w(N_REQ);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_n_c;
    logic [N_REQ-1:0]   elig_c;
    logic [N_REQ-1:0]   win_c;
    logic               valid_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic [DATA_W-1:0]  sel_data_c;
    logic               oob_c;
    logic               zero_c;
    logic [N_REGS-1:0]  wr_en_n_c;

    assign bus.busy = |bus.req;

    // Last cycle's grantee is masked so a held request is never granted twice.
    assign elig_c = bus.req & ~bus.gnt;

    rr_picker #(.N(N_REQ)) u_pick (
        .elig    (elig_c),
        .ptr     (ptr),
        .win_c   (win_c),
        .valid_c (valid_c)
    );

    // Winner mux, next pointer and target decode.
    always_comb begin
        sel_addr_c = '0;
        sel_data_c = '0;
        ptr_n_c    = ptr;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_c[i]) begin
                sel_addr_c = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data_c = bus.req_data[i*DATA_W +: DATA_W];
                ptr_n_c    = (i == int'(N_REQ) - 1) ? '0 : PTR_W'(i + 1);
            end
        end
        oob_c = 32'(sel_addr_c) >= N_REGS;
`ifdef ZERO_REG_PROTECT_EN
        zero_c = (sel_addr_c == '0);
`else
        zero_c = 1'b0;
`endif
        wr_en_n_c = (oob_c || zero_c) ? '0 : (N_REGS'(1) << sel_addr_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            bus.gnt      <= '0;
            bus.wr_en    <= '0;
            bus.wr_data  <= '0;
            bus.addr_err <= 1'b0;
        end else if (!bus.stall && valid_c) begin
            ptr          <= ptr_n_c;
            bus.gnt      <= win_c;
            bus.wr_en    <= wr_en_n_c;
            bus.wr_data  <= sel_data_c;
            bus.addr_err <= oob_c;
        end else begin
            bus.gnt      <= '0;
            bus.wr_en    <= '0;
            bus.addr_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a 12-register bank model.
module tb_regfile_write_arbiter;
    localparam int unsigned N_REQ  = 3;
    localparam int unsigned N_REGS = 12;
    localparam int unsigned DATA_W = 20;
    localparam int unsigned ADDR_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic bank_init;
    logic [DATA_W-1:0] bank [N_REGS];
    int n_tests = 0;
    int n_fail  = 0;

    regfile_write_arbiter_if #(.N_REQ(N_REQ), .N_REGS(N_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(.N_REQ(N_REQ), .N_REGS(N_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register bank captures the arbiter's write at the rising edge.
    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < int'(N_REGS); i++) bank[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_REGS); i++)
                if (bus.wr_en[i]) bank[i] <= bus.wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bank_init = 1'b1; bus.stall = 1'b0; bus.req = 3'b111;
        bus.req_addr = {4'd3, 4'd2, 4'd1};
        bus.req_data = {20'h0C0C0, 20'h0B0B0, 20'h0A0A0};
        tick(); tick();
        bank_init = 1'b0;
        n_tests++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", bus.gnt); end
        n_tests++; if (bus.wr_en !== 12'h000) begin n_fail++; $display("FAIL reset_wr_en got %h want 000", bus.wr_en); end
        n_tests++; if (bus.wr_data !== 20'h00000) begin n_fail++; $display("FAIL reset_wr_data got %h want 00000", bus.wr_data); end
        n_tests++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err got %b want 0", bus.addr_err); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", bus.busy); end
        rst = 1'b0;
        tick();
        n_tests++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL first_gnt got %b want 001", bus.gnt); end
        n_tests++; if (bus.wr_en !== 12'h002) begin n_fail++; $display("FAIL first_wr_en got %h want 002", bus.wr_en); end
        n_tests++; if (bus.wr_data !== 20'h0A0A0) begin n_fail++; $display("FAIL first_wr_data got %h want 0a0a0", bus.wr_data); end
        bus.req = 3'b000;
        tick();
        n_tests++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL first_gnt_end got %b want 000", bus.gnt); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_single_write();
        bus.req = 3'b010;
        bus.req_addr = {4'd0, 4'd5, 4'd0};
        bus.req_data = {20'h0, 20'h0ABCD, 20'h0};
        tick();
        n_tests++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL single_gnt got %b want 010", bus.gnt); end
        n_tests++; if (bus.wr_en !== 12'h020) begin n_fail++; $display("FAIL single_wr_en got %h want 020", bus.wr_en); end
        n_tests++; if (bus.wr_data !== 20'h0ABCD) begin n_fail++; $display("FAIL single_wr_data got %h want 0abcd", bus.wr_data); end
        bus.req = 3'b000;
        tick();
        n_tests++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL single_gnt_end got %b want 000", bus.gnt); end
        n_tests++; if (bus.wr_en !== 12'h000) begin n_fail++; $display("FAIL single_wr_en_end got %h want 000", bus.wr_en); end
        n_tests++; if (bus.wr_data !== 20'h0ABCD) begin n_fail++; $display("FAIL single_wr_data_hold got %h want 0abcd", bus.wr_data); end
        n_tests++; if (bank[5] !== 20'h0ABCD) begin n_fail++; $display("FAIL single_bank5 got %h want 0abcd", bank[5]); end
    endtask

    task automatic test_contention();
        logic [2:0]  exp_gnt [6];
        logic [11:0] exp_en  [6];
        logic [19:0] exp_dat [6];
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_en  = '{12'h008, 12'h010, 12'h020, 12'h008, 12'h010, 12'h020};
        exp_dat = '{20'h0A000, 20'h0B001, 20'h0C002, 20'h0A000, 20'h0B001, 20'h0C002};
        rst = 1'b1; bus.req = 3'b000;
        tick();
        rst = 1'b0;
        bus.req = 3'b111;
        bus.req_addr = {4'd5, 4'd4, 4'd3};
        bus.req_data = {20'h0C002, 20'h0B001, 20'h0A000};
        for (int k = 0; k < 6; k++) begin
            tick();
            n_tests++;
            if (bus.gnt !== exp_gnt[k] || bus.wr_en !== exp_en[k] || bus.wr_data !== exp_dat[k]) begin
                n_fail++;
                $display("FAIL contention_%0d got gnt=%b en=%h d=%h want gnt=%b en=%h d=%h",
                         k, bus.gnt, bus.wr_en, bus.wr_data, exp_gnt[k], exp_en[k], exp_dat[k]);
            end
        end
        bus.req = 3'b000;
        tick();
        n_tests++; if (bank[4] !== 20'h0B001) begin n_fail++; $display("FAIL contention_bank4 got %h want 0b001", bank[4]); end
    endtask

    task automatic test_stall();
        bus.req = 3'b001;
        bus.req_addr = {4'd9, 4'd0, 4'd7};
        bus.req_data = {20'h33333, 20'h0, 20'h11111};
        tick();
        n_tests++; if (bus.wr_en !== 12'h080) begin n_fail++; $display("FAIL stall_pre_wr_en got %h want 080", bus.wr_en); end
        bus.req = 3'b000;
        tick();
        bus.req = 3'b101; bus.stall = 1'b1;
        bus.req_data = {20'h33333, 20'h0, 20'h22222};
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (bus.gnt !== 3'b000 || bus.wr_en !== 12'h000) begin
                n_fail++;
                $display("FAIL stall_hold_%0d got gnt=%b en=%h want gnt=000 en=000", k, bus.gnt, bus.wr_en);
            end
        end
        bus.stall = 1'b0;
        tick();
        n_tests++; if (bus.gnt !== 3'b100) begin n_fail++; $display("FAIL stall_release_gnt got %b want 100", bus.gnt); end
        n_tests++; if (bus.wr_en !== 12'h200 || bus.wr_data !== 20'h33333) begin
            n_fail++; $display("FAIL stall_release_wr got en=%h d=%h want en=200 d=33333", bus.wr_en, bus.wr_data); end
        bus.stall = 1'b1;
        tick();
        n_tests++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL stall_mid_gnt got %b want 000", bus.gnt); end
        n_tests++; if (bank[9] !== 20'h33333 || bank[7] !== 20'h11111) begin
            n_fail++; $display("FAIL stall_mid_bank got b9=%h b7=%h want b9=33333 b7=11111", bank[9], bank[7]); end
        bus.stall = 1'b0; bus.req = 3'b000;
        tick();
    endtask

    task automatic test_addr();
        logic [11:0] exp_en0;
        logic [19:0] exp_b0;
`ifdef ZERO_REG_PROTECT_EN
        exp_en0 = 12'h000; exp_b0 = 20'h00000;
`else
        exp_en0 = 12'h001; exp_b0 = 20'h55555;
`endif
        bus.req = 3'b001;
        bus.req_addr = {4'd0, 4'd0, 4'd14};
        bus.req_data = {20'h0, 20'h55555, 20'h44444};
        tick();
        n_tests++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL oob_gnt got %b want 001", bus.gnt); end
        n_tests++; if (bus.wr_en !== 12'h000) begin n_fail++; $display("FAIL oob_wr_en got %h want 000", bus.wr_en); end
        n_tests++; if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL oob_addr_err got %b want 1", bus.addr_err); end
        bus.req = 3'b000;
        tick();
        n_tests++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL oob_addr_err_end got %b want 0", bus.addr_err); end
        bus.req = 3'b010;
        tick();
        n_tests++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL zero_gnt got %b want 010", bus.gnt); end
        n_tests++; if (bus.wr_en !== exp_en0) begin n_fail++; $display("FAIL zero_wr_en got %h want %h", bus.wr_en, exp_en0); end
        n_tests++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL zero_addr_err got %b want 0", bus.addr_err); end
        bus.req = 3'b000;
        tick();
        n_tests++; if (bank[0] !== exp_b0) begin n_fail++; $display("FAIL zero_bank0 got %h want %h", bank[0], exp_b0); end
    endtask

    task automatic test_reset_mid_write();
        bus.req = 3'b100;
        bus.req_addr = {4'd4, 4'd8, 4'd6};
        bus.req_data = {20'h77777, 20'h0E00E, 20'h0D00D};
        rst = 1'b1;
        tick();
        n_tests++; if (bus.gnt !== 3'b000 || bus.wr_en !== 12'h000) begin
            n_fail++; $display("FAIL rstmid_out got gnt=%b en=%h want gnt=000 en=000", bus.gnt, bus.wr_en); end
        bus.req = 3'b000;
        tick();
        n_tests++; if (bank[4] !== 20'h0B001) begin n_fail++; $display("FAIL rstmid_bank4 got %h want 0b001", bank[4]); end
        rst = 1'b0; bus.req = 3'b111;
        tick();
        n_tests++; if (bus.gnt !== 3'b001 || bus.wr_en !== 12'h040 || bus.wr_data !== 20'h0D00D) begin
            n_fail++; $display("FAIL rstmid_ptr got gnt=%b en=%h d=%h want gnt=001 en=040 d=0d00d",
                                bus.gnt, bus.wr_en, bus.wr_data); end
        bus.req = 3'b000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_stall();
        test_addr();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
